// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory access, byte/half/word lanes.
// Optional macro LSU_MISALIGN_TRAP_EN blocks misaligned half/word accesses.
module lsu #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic                  data_req_o,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int W = WORD_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  state_e         state_q, state_d;
  size_e          size_q, size_d;
  size_e          size_n;
  logic [W-1:0]   addr_q, addr_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic [3:0]     be_q, be_d;
  logic [3:0]     be_n;
  logic [1:0]     off_q, off_d;
  logic [1:0]     off_n;
  logic           we_q, we_d;
  logic           uns_q, uns_d;
  logic           mis;
  logic           accept;
  logic [W-1:0]   shifted;
  logic [W-1:0]   ext;

  always_comb begin
    size_n = SZ_W;
    if (we_i) begin
      unique case (store_type_i)
        2'b00:   size_n = SZ_B;
        2'b01:   size_n = SZ_H;
        default: size_n = SZ_W;
      endcase
    end else begin
      unique case (load_type_i[1:0])
        2'b00:   size_n = SZ_B;
        2'b01:   size_n = SZ_H;
        default: size_n = SZ_W;
      endcase
    end
  end

  always_comb begin
    off_n = 2'b00;
    be_n  = 4'b1111;
    mis   = 1'b0;
    unique case (size_n)
      SZ_B: begin
        off_n = addr_i[1:0];
        be_n  = 4'b0001 << off_n;
      end
      SZ_H: begin
        off_n = {addr_i[1], 1'b0};
        be_n  = 4'b0011 << off_n;
      end
      default: begin
        off_n = 2'b00;
        be_n  = 4'b1111;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((size_n == SZ_H) && addr_i[0]) ||
          ((size_n == SZ_W) && (addr_i[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
  end

  assign accept = (state_q == IDLE) && req_i && !mis;

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    off_d   = off_q;
    we_d    = we_q;
    uns_d   = uns_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT_GNT;
          size_d  = size_n;
          addr_d  = {addr_i[W-1:2], 2'b00};
          wdata_d = wdata_i << {off_n, 3'b000};
          be_d    = be_n;
          off_d   = off_n;
          we_d    = we_i;
          uns_d   = load_type_i[2];
        end
      end
      WAIT_GNT: begin
        if (data_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      size_q  <= SZ_W;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      off_q   <= off_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
    end
  end

  assign shifted = data_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ext = data_rdata_i;
    unique case (size_q)
      SZ_B: ext = uns_q ? {{(W-8){1'b0}}, shifted[7:0]}
                        : {{(W-8){shifted[7]}}, shifted[7:0]};
      SZ_H: ext = uns_q ? {{(W-16){1'b0}}, shifted[15:0]}
                        : {{(W-16){shifted[15]}}, shifted[15:0]};
      default: ext = data_rdata_i;
    endcase
  end

  assign data_req_o   = (state_q == WAIT_GNT);
  assign data_addr_o  = addr_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;
  assign valid_o      = (state_q == WAIT_RVALID) && data_rvalid_i;
  assign rdata_o      = valid_o ? ext : '0;
  // Gated by rst_n so these read 0 even if req_i is high during reset.
  assign busy_o       = rst_n && ((state_q != IDLE) || accept);
  assign err_o        = rst_n && (state_q == IDLE) && req_i && mis;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
// Misalignment expectations follow LSU_MISALIGN_TRAP_EN.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        we_i;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic [31:0] rdata_o;
  logic        valid_o;
  logic        busy_o;
  logic        err_o;

  int checks = 0;
  int fails  = 0;

  lsu #(.WORD_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .we_i         (we_i),
    .load_type_i  (load_type_i),
    .store_type_i (store_type_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .data_req_o   (data_req_o),
    .data_addr_o  (data_addr_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_wdata_o (data_wdata_o),
    .data_gnt_i   (data_gnt_i),
    .data_rvalid_i(data_rvalid_i),
    .data_rdata_i (data_rdata_i),
    .rdata_o      (rdata_o),
    .valid_o      (valid_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic we,
                       input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic [31:0] exp_rd,
                       input logic [31:0] exp_a, input logic [31:0] exp_wd,
                       input logic [3:0] exp_be, input int dly);
    int cyc;
    req_i = 1'b1;
    we_i = we;
    load_type_i = lt;
    store_type_i = st;
    addr_i = a;
    wdata_i = wd;
    #1;
    chk({tag, "_busy_req"}, 32'(busy_o), 32'd1);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    tick();
    cyc = 1;
    req_i = 1'b0;
    addr_i = 32'hFFFF_FFFF;
    wdata_i = ~wd;
    for (int i = 0; i <= dly; i++) begin
      data_gnt_i = (i == dly);
      #1;
      chk({tag, "_dreq"}, 32'(data_req_o), 32'd1);
      chk({tag, "_addr"}, data_addr_o, exp_a);
      chk({tag, "_be"}, 32'(data_be_o), 32'(exp_be));
      chk({tag, "_wdata"}, data_wdata_o, exp_wd);
      chk({tag, "_we"}, 32'(data_we_o), 32'(we));
      chk({tag, "_busy_wait"}, 32'(busy_o), 32'd1);
      chk({tag, "_valid_early"}, 32'(valid_o), 32'd0);
      tick();
      cyc++;
    end
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i = rd;
    #1;
    chk({tag, "_dreq_off"}, 32'(data_req_o), 32'd0);
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_busy_done"}, 32'(busy_o), 32'd1);
    chk({tag, "_latency"}, 32'(cyc + 1), 32'(dly + 3));
    if (!we) chk({tag, "_rdata"}, rdata_o, exp_rd);
    tick();
    data_rvalid_i = 1'b0;
    #1;
    chk({tag, "_valid_off"}, 32'(valid_o), 32'd0);
    chk({tag, "_busy_off"}, 32'(busy_o), 32'd0);
    chk({tag, "_dreq_idle"}, 32'(data_req_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_i = 1'b1;
    we_i = 1'b1;
    load_type_i = 3'b000;
    store_type_i = 2'b10;
    addr_i = 32'h0000_0123;
    wdata_i = 32'h1111_1111;
    data_gnt_i = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'hFFFF_FFFF;
    tick();
    tick();
    chk("rst_dreq", 32'(data_req_o), 32'd0);
    chk("rst_addr", data_addr_o, 32'd0);
    chk("rst_we", 32'(data_we_o), 32'd0);
    chk("rst_be", 32'(data_be_o), 32'd0);
    chk("rst_wdata", data_wdata_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    req_i = 1'b0;
    data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0;
    rst_n = 1'b1;
    tick();

    do_op("lb", 1'b0, 3'b000, 2'b00, 32'h103, 32'h0, 32'h80FF_FF12,
          32'hFFFF_FF80, 32'h100, 32'h0, 4'b1000, 0);
    do_op("lbu", 1'b0, 3'b100, 2'b00, 32'h103, 32'h0, 32'h80FF_FF12,
          32'h0000_0080, 32'h100, 32'h0, 4'b1000, 0);
    do_op("lh", 1'b0, 3'b001, 2'b00, 32'h102, 32'h0, 32'h8001_1234,
          32'hFFFF_8001, 32'h100, 32'h0, 4'b1100, 1);
    do_op("lhu", 1'b0, 3'b101, 2'b00, 32'h100, 32'h0, 32'h8001_9234,
          32'h0000_9234, 32'h100, 32'h0, 4'b0011, 0);
    do_op("lt_undef", 1'b0, 3'b011, 2'b00, 32'h300, 32'h0, 32'h1234_5678,
          32'h1234_5678, 32'h300, 32'h0, 4'b1111, 0);
    do_op("sh", 1'b1, 3'b000, 2'b01, 32'h102, 32'h0000_1234, 32'h0,
          32'h0, 32'h100, 32'h1234_0000, 4'b1100, 0);
    do_op("sb", 1'b1, 3'b000, 2'b00, 32'h101, 32'h1122_33AB, 32'h0,
          32'h0, 32'h100, 32'h2233_AB00, 4'b0010, 2);
    do_op("sw_stall", 1'b1, 3'b000, 2'b10, 32'h200, 32'hDEAD_BEEF, 32'h0,
          32'h0, 32'h200, 32'hDEAD_BEEF, 4'b1111, 3);
    do_op("st_undef", 1'b1, 3'b000, 2'b11, 32'h204, 32'hCAFE_F00D, 32'h0,
          32'h0, 32'h204, 32'hCAFE_F00D, 4'b1111, 0);
    do_op("b2b_0", 1'b0, 3'b010, 2'b00, 32'h10, 32'h0, 32'hAAAA_5555,
          32'hAAAA_5555, 32'h10, 32'h0, 4'b1111, 0);
    do_op("b2b_1", 1'b0, 3'b010, 2'b00, 32'h14, 32'h0, 32'h0F0F_F0F0,
          32'h0F0F_F0F0, 32'h14, 32'h0, 4'b1111, 0);

`ifdef LSU_MISALIGN_TRAP_EN
    req_i = 1'b1;
    we_i = 1'b0;
    load_type_i = 3'b010;
    addr_i = 32'h101;
    #1;
    chk("mis_err", 32'(err_o), 32'd1);
    chk("mis_busy", 32'(busy_o), 32'd0);
    tick();
    req_i = 1'b0;
    #1;
    chk("mis_err_off", 32'(err_o), 32'd0);
    chk("mis_dreq", 32'(data_req_o), 32'd0);
    tick();
    chk("mis_dreq2", 32'(data_req_o), 32'd0);
`else
    do_op("mis_lw", 1'b0, 3'b010, 2'b00, 32'h101, 32'h0, 32'h7654_3210,
          32'h7654_3210, 32'h100, 32'h0, 4'b1111, 0);
`endif

    req_i = 1'b1;
    we_i = 1'b0;
    load_type_i = 3'b010;
    addr_i = 32'h40;
    tick();
    req_i = 1'b0;
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(valid_o), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    chk("rst_mid_addr", data_addr_o, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    data_rvalid_i = 1'b1;
    data_rdata_i = 32'h0000_0055;
    #1;
    chk("late_rvalid_valid", 32'(valid_o), 32'd0);
    chk("late_rvalid_busy", 32'(busy_o), 32'd0);
    chk("late_rvalid_rdata", rdata_o, 32'd0);
    tick();
    data_rvalid_i = 1'b0;
    #1;
    chk("late_rvalid_dreq", 32'(data_req_o), 32'd0);
    chk("late_rvalid_busy2", 32'(busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter WORD_WIDTH, default 32, SHALL set the data and address width.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req_i  in  1  SHALL be the memory-operation request from the EX/WB register.
REQ-005 we_i  in  1  SHALL select store when 1 and load when 0.
REQ-006 load_type_i  in  3  SHALL use funct3 coding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-007 store_type_i  in  2  SHALL use the coding 00 SB, 01 SH, 10 SW.
REQ-008 addr_i / wdata_i  in  WORD_WIDTH  SHALL be the byte address and the unshifted store data.
REQ-009 data_req_o, data_addr_o, data_we_o, data_be_o[3:0], data_wdata_o  out  SHALL form the data-memory request channel.
REQ-010 data_gnt_i, data_rvalid_i, data_rdata_i  in  SHALL form the data-memory grant and response channel.
REQ-011 rdata_o  out  WORD_WIDTH  SHALL carry the aligned, extended load result.
REQ-012 valid_o  out  1  SHALL flag that an operation has completed.
REQ-013 busy_o  out  1  SHALL request a pipeline stall.
REQ-014 err_o  out  1  SHALL pulse on a misaligned access.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT_GNT and WAIT_RVALID.
REQ-016 In IDLE, req_i=1 SHALL latch the address, we, byte enables and shifted wdata, then move to WAIT_GNT.
REQ-017 data_req_o SHALL be 1 exactly while in WAIT_GNT, and the latched request outputs SHALL stay stable until data_gnt_i=1.
REQ-018 In WAIT_GNT, data_gnt_i=1 SHALL move the FSM to WAIT_RVALID; data_rvalid_i SHALL be ignored in that cycle.
REQ-019 In WAIT_RVALID, data_rvalid_i=1 SHALL assert valid_o combinationally for that cycle and return the FSM to IDLE.
REQ-020 Stores SHALL also wait for data_rvalid_i; rdata_o is don't-care for stores.
REQ-021 data_addr_o SHALL be the word-aligned address addr_i with bits [1:0] forced to 0.
REQ-022 Byte enables SHALL be: SB 0001 shifted left by addr[1:0]; SH 0011 shifted left by addr[1] times 2; SW 1111.
REQ-023 data_wdata_o SHALL be wdata_i shifted left by 8 times addr[1:0] (SB) or 16 times addr[1] (SH), and unshifted for SW.
REQ-024 Load data SHALL be right-shifted by the latched offset, then sign-extended (LB, LH) or zero-extended (LBU, LHU); LW is passed through.
REQ-025 busy_o SHALL equal (state != IDLE) OR (state == IDLE AND req_i), with no clear in the cycle valid_o is high.
REQ-026 A request arriving in the same cycle as completion SHALL only be accepted in the following IDLE cycle.
REQ-027 Undefined load_type_i or store_type_i codes SHALL be treated as LW or SW respectively.

Reset
REQ-028 While rst_n=0 the FSM SHALL be in IDLE and every output SHALL be 0: data_req_o, data_we_o, data_be_o, data_wdata_o, data_addr_o, rdata_o, valid_o, busy_o and err_o.
REQ-029 Reset during WAIT_GNT or WAIT_RVALID SHALL abandon the transaction; a late data_rvalid_i after reset SHALL be ignored in IDLE.

Configuration
REQ-030 With LSU_MISALIGN_TRAP_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL not be issued.
REQ-031 In that case err_o SHALL pulse high for exactly one cycle, the FSM SHALL stay in IDLE, and busy_o SHALL be 0.
REQ-032 Without LSU_MISALIGN_TRAP_EN, err_o SHALL be tied to 0 and the low address bits SHALL be silently truncated per REQ-022 and REQ-023.

Verification
REQ-033 LB at addr 0x103, rdata 0x80FF_FF12 -> rdata_o = 0xFFFF_FF80; LBU at the same address -> 0x0000_0080.
REQ-034 SH at addr 0x102, wdata 0x0000_1234 -> data_addr_o = 0x100, data_be_o = 1100, data_wdata_o = 0x1234_0000.
REQ-035 SW with data_gnt_i held low for 3 cycles -> data_req_o high for 4 cycles, outputs stable, busy_o high until valid_o.
REQ-036 LW at 0x101 with LSU_MISALIGN_TRAP_EN -> data_req_o stays 0 and err_o pulses for 1 cycle; without the macro -> access issued at 0x100.
REQ-037 rst_n low while in WAIT_RVALID, then data_rvalid_i=1 one cycle after release -> valid_o stays 0 and the FSM stays in IDLE.
REQ-038 Back-to-back LW, LW with gnt and rvalid immediate -> each takes 3 cycles from request to valid_o, with no overlap.
